// File: rtl/fft_out_reorder_pkg.sv
// rtl/fft_out_reorder_pkg.sv - FFT reorder sizes, bit-reverse helper and read-state encoding
package fft_pkg;

   localparam int N_POINTS = 16;
   localparam int LOG2N    = 4;
   localparam int DATA_W   = 16;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_RUN  = 1'b1
   } rd_state_t;

   // Mirror the LOG2N-bit index: bit i moves to bit LOG2N-1-i.
   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) begin
         r[i] = a[LOG2N-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// rtl/fft_out_reorder_if.sv - sample-in / sample-out bus of the reorder buffer (FFT_REORDER_SYNC_EN adds in_sof/sync_err)
interface fft_out_reorder_if;
   import fft_pkg::*;

   logic              in_valid;
   logic [DATA_W-1:0] in_re;
   logic [DATA_W-1:0] in_im;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_re;
   logic [DATA_W-1:0] out_im;
   logic [LOG2N-1:0]  out_index;
   logic              out_last;
   logic              out_ready;
`ifdef FFT_REORDER_SYNC_EN
   logic              in_sof;
   logic              sync_err;

   modport master (
      output in_valid, in_re, in_im, in_sof, out_ready,
      input  in_ready, out_valid, out_re, out_im, out_index, out_last, sync_err
   );

   modport slave (
      input  in_valid, in_re, in_im, in_sof, out_ready,
      output in_ready, out_valid, out_re, out_im, out_index, out_last, sync_err
   );
`else
   modport master (
      output in_valid, in_re, in_im, out_ready,
      input  in_ready, out_valid, out_re, out_im, out_index, out_last
   );

   modport slave (
      input  in_valid, in_re, in_im, out_ready,
      output in_ready, out_valid, out_re, out_im, out_index, out_last
   );
`endif

endinterface

// File: rtl/fft_out_reorder_bank.sv
// rtl/fft_out_reorder_bank.sv - two-bank sample store, one write port and one asynchronous read port
module fft_reorder_bank
   import fft_pkg::*;
(
   input  logic                clk,
   input  logic                wr_en_i,
   input  logic                wr_bank_i,
   input  logic [LOG2N-1:0]    wr_addr_i,
   input  logic [2*DATA_W-1:0] wr_data_i,
   input  logic                rd_bank_i,
   input  logic [LOG2N-1:0]    rd_addr_i,
   output logic [2*DATA_W-1:0] rd_data_o
);

   // Bank select is the top address bit, so both banks share one array.
   logic [2*DATA_W-1:0] mem_q [2*N_POINTS];

   // Store one {re, im} sample per accepted write.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[{rd_bank_i, rd_addr_i}];

endmodule

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong bit-reversed to natural-order FFT output buffer (optional FFT_REORDER_SYNC_EN)
module fft_out_reorder
   import fft_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   fft_out_reorder_if.slave bus
);

   localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);
   localparam logic [LOG2N-1:0] ONE      = LOG2N'(1);

   logic [LOG2N-1:0]    wr_cnt_q, wr_cnt_d;
   logic                wr_bank_q, wr_bank_d;
   logic [1:0]          full_q, full_d, set_full, clr_full;
   logic                accept, normal_wr, wr_en;
   logic [LOG2N-1:0]    wr_addr;

   rd_state_t           state_q;
   logic [LOG2N-1:0]    rd_cnt_q;
   logic                rd_bank_q;
   logic                load;
   logic [2*DATA_W-1:0] rd_data;

   logic                out_valid_q;
   logic [DATA_W-1:0]   out_re_q, out_im_q;
   logic [LOG2N-1:0]    out_index_q;
   logic                out_last_q;

   // The writer only stalls when the bank it is about to fill is still unread.
   assign bus.in_ready = ~full_q[wr_bank_q];
   assign accept       = bus.in_valid & ~full_q[wr_bank_q];

`ifdef FFT_REORDER_SYNC_EN
   logic sync_err_q, sync_err_d;
   logic sof_restart, sof_missing;

   // A start-of-frame mid-frame restarts the frame; a missing one drops the sample.
   assign sof_restart   = accept &  bus.in_sof & (wr_cnt_q != '0);
   assign sof_missing   = accept & ~bus.in_sof & (wr_cnt_q == '0);
   assign normal_wr     = accept & ~sof_restart & ~sof_missing;
   assign sync_err_d    = sync_err_q | sof_restart | sof_missing;
   assign bus.sync_err  = sync_err_q;

   // Sticky framing-error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_err_q <= 1'b0;
      end else begin
         sync_err_q <= sync_err_d;
      end
   end
`else
   logic sof_restart;

   assign sof_restart = 1'b0;
   assign normal_wr   = accept;
`endif

   // Write address, counter advance and frame completion.
   always_comb begin
      wr_en     = normal_wr | sof_restart;
      wr_addr   = sof_restart ? '0 : bitrev(wr_cnt_q);
      wr_cnt_d  = wr_cnt_q;
      wr_bank_d = wr_bank_q;
      set_full  = 2'b00;
      if (sof_restart) begin
         wr_cnt_d = ONE;
      end else if (normal_wr) begin
         wr_cnt_d = wr_cnt_q + ONE;
         if (wr_cnt_q == LAST_IDX) begin
            set_full[wr_bank_q] = 1'b1;
            wr_bank_d           = ~wr_bank_q;
         end
      end
   end

   // A bank is readable as soon as it is full, even before the FSM leaves idle,
   // which keeps the first output one cycle after the frame completes.
   assign load = ((state_q == RD_RUN) | full_q[rd_bank_q]) & (~out_valid_q | bus.out_ready);

   // Reading the last bin frees the bank; writer set and reader clear can coincide.
   always_comb begin
      clr_full = 2'b00;
      if (load && (rd_cnt_q == LAST_IDX)) begin
         clr_full[rd_bank_q] = 1'b1;
      end
   end

   assign full_d = (full_q | set_full) & ~clr_full;

   // Writer state and the shared full flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt_q  <= '0;
         wr_bank_q <= 1'b0;
         full_q    <= 2'b00;
      end else begin
         wr_cnt_q  <= wr_cnt_d;
         wr_bank_q <= wr_bank_d;
         full_q    <= full_d;
      end
   end

   // Read FSM with the registered output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RD_IDLE;
         rd_cnt_q    <= '0;
         rd_bank_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
         out_index_q <= '0;
         out_last_q  <= 1'b0;
      end else if (load) begin
         out_valid_q <= 1'b1;
         out_re_q    <= rd_data[2*DATA_W-1:DATA_W];
         out_im_q    <= rd_data[DATA_W-1:0];
         out_index_q <= rd_cnt_q;
         out_last_q  <= (rd_cnt_q == LAST_IDX);
         rd_cnt_q    <= rd_cnt_q + ONE;
         if (rd_cnt_q == LAST_IDX) begin
            rd_bank_q <= ~rd_bank_q;
            state_q   <= full_q[~rd_bank_q] ? RD_RUN : RD_IDLE;
         end else begin
            state_q   <= RD_RUN;
         end
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   fft_reorder_bank u_bank (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_bank_i (wr_bank_q),
      .wr_addr_i (wr_addr),
      .wr_data_i ({bus.in_re, bus.in_im}),
      .rd_bank_i (rd_bank_q),
      .rd_addr_i (rd_cnt_q),
      .rd_data_o (rd_data)
   );

   assign bus.out_valid = out_valid_q;
   assign bus.out_re    = out_re_q;
   assign bus.out_im    = out_im_q;
   assign bus.out_index = out_index_q;
   assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb/tb_fft_out_reorder.sv - self-checking bench for fft_out_reorder
module tb_fft_out_reorder;
   import fft_pkg::*;

   typedef struct packed {
      logic [DATA_W-1:0] re;
      logic [DATA_W-1:0] im;
      logic [LOG2N-1:0]  idx;
      logic              last;
   } out_t;

   typedef struct {
      logic              in_valid;
      logic [DATA_W-1:0] in_re;
      logic [DATA_W-1:0] in_im;
      logic              out_ready;
      logic              exp_in_ready;
      logic              exp_valid;
      logic [DATA_W-1:0] exp_re;
      logic [DATA_W-1:0] exp_im;
      logic [LOG2N-1:0]  exp_idx;
      logic              exp_last;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fft_out_reorder_if bus ();

   fft_out_reorder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int                errors  = 0;
   int                checks  = 0;
   int                n_out   = 0;
   int                n_acc   = 0;
   out_t              exp_q[$];
   logic [DATA_W-1:0] cur_re[N_POINTS];
   logic [DATA_W-1:0] cur_im[N_POINTS];
   int                cur_cnt  = 0;
   logic              exp_sync = 1'b0;
   vec_t              vec[34];

   function automatic void check(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endfunction

   function automatic int tb_bitrev(int v);
      int r = 0;
      int x = v;
      for (int b = 0; b < LOG2N; b++) begin
         r = r * 2 + (x % 2);
         x = x / 2;
      end
      return r;
   endfunction

   // Reference: collect arrival-order samples; a full frame is emitted in natural order.
   function automatic void model_accept(logic [DATA_W-1:0] re, logic [DATA_W-1:0] im, logic sof);
      out_t nat[N_POINTS];
      int   j;
`ifdef FFT_REORDER_SYNC_EN
      if (sof && cur_cnt != 0) begin
         exp_sync = 1'b1;
         cur_cnt  = 0;
      end else if (!sof && cur_cnt == 0) begin
         exp_sync = 1'b1;
         return;
      end
`else
      if (sof) exp_sync = 1'b1;
`endif
      cur_re[cur_cnt] = re;
      cur_im[cur_cnt] = im;
      cur_cnt++;
      if (cur_cnt == N_POINTS) begin
         for (int k = 0; k < N_POINTS; k++) begin
            j = tb_bitrev(k);
            nat[j].re   = cur_re[k];
            nat[j].im   = cur_im[k];
            nat[j].idx  = LOG2N'(j);
            nat[j].last = (j == N_POINTS - 1);
         end
         for (int k = 0; k < N_POINTS; k++) exp_q.push_back(nat[k]);
         cur_cnt = 0;
      end
   endfunction

   // One clock: record what handshakes at the edge, then check against the model.
   task automatic step();
      logic              was_rst, acc, hs, stall, sof;
      logic [DATA_W-1:0] a_re, a_im;
      out_t              held, now_o, e;
      was_rst = rst;
      acc     = bus.in_valid && bus.in_ready;
      hs      = bus.out_valid && bus.out_ready;
      stall   = bus.out_valid && !bus.out_ready;
      a_re    = bus.in_re;
      a_im    = bus.in_im;
`ifdef FFT_REORDER_SYNC_EN
      sof = bus.in_sof;
`else
      sof = 1'b0;
`endif
      held.re = bus.out_re; held.im = bus.out_im; held.idx = bus.out_index; held.last = bus.out_last;
      @(posedge clk);
      #1;
      if (was_rst) begin
         exp_q.delete();
         cur_cnt  = 0;
         exp_sync = 1'b0;
      end else begin
         if (hs) begin
            n_out++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL out_unexpected: got re=%h idx=%0d, want no output", held.re, held.idx);
            end else begin
               e = exp_q.pop_front();
               if (held !== e) begin
                  errors++;
                  $display("FAIL out_data: got re=%h im=%h idx=%0d last=%b, want re=%h im=%h idx=%0d last=%b",
                           held.re, held.im, held.idx, held.last, e.re, e.im, e.idx, e.last);
               end
            end
         end
         if (stall) begin
            now_o.re = bus.out_re; now_o.im = bus.out_im; now_o.idx = bus.out_index; now_o.last = bus.out_last;
            checks++;
            if (!bus.out_valid || now_o !== held) begin
               errors++;
               $display("FAIL out_hold: got valid=%b re=%h idx=%0d, want valid=1 re=%h idx=%0d",
                        bus.out_valid, now_o.re, now_o.idx, held.re, held.idx);
            end
         end
         if (acc) begin
            n_acc++;
            model_accept(a_re, a_im, sof);
         end
      end
   endtask

   task automatic set_in(logic v, logic [DATA_W-1:0] re, logic [DATA_W-1:0] im);
      bus.in_valid = v;
      bus.in_re    = re;
      bus.in_im    = im;
`ifdef FFT_REORDER_SYNC_EN
      bus.in_sof   = (cur_cnt == 0);
`endif
   endtask

   // Offer fresh random samples until n are accepted; out_ready is high rdy_pct percent of cycles.
   task automatic send(int n, int rdy_pct);
      int                got = 0;
      int                guard = 0;
      logic              took;
      logic [DATA_W-1:0] r, i;
      r = DATA_W'($urandom);
      i = DATA_W'($urandom);
      while (got < n && guard < 2000) begin
         bus.out_ready = (int'($urandom_range(99)) < rdy_pct);
         set_in(1'b1, r, i);
         took = bus.in_ready;
         step();
         if (took) begin
            got++;
            r = DATA_W'($urandom);
            i = DATA_W'($urandom);
         end
         guard++;
      end
      set_in(1'b0, '0, '0);
      check("send_accepts", got, n);
   endtask

   task automatic drain(string name);
      int guard = 0;
      set_in(1'b0, '0, '0);
      bus.out_ready = 1'b1;
      while ((exp_q.size() != 0 || bus.out_valid) && guard < 200) begin
         step();
         guard++;
      end
      check({name, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish before 200us");
      $fatal(1);
   end

   initial begin
      int                base, gaps, ir_low, acc, extra, g;
      logic              seen, took, prev_ir;
      logic [DATA_W-1:0] r, i, first_re;

      bus.in_valid  = 1'b0;
      bus.in_re     = '0;
      bus.in_im     = '0;
      bus.out_ready = 1'b0;
`ifdef FFT_REORDER_SYNC_EN
      bus.in_sof    = 1'b0;
`endif

      // Reset state.
      rst = 1'b1;
      step();
      step();
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_re", bus.out_re, 0);
      check("rst_out_im", bus.out_im, 0);
      check("rst_out_index", bus.out_index, 0);
      check("rst_out_last", bus.out_last, 0);
`ifdef FFT_REORDER_SYNC_EN
      check("rst_sync_err", bus.sync_err, 0);
`endif
      rst = 1'b0;

      // Single frame table: re=bitrev(k), im=-re; outputs come back 0..15.
      for (int k = 0; k < 34; k++) begin
         vec[k].in_valid     = (k < 16);
         vec[k].in_re        = (k < 16) ? DATA_W'(tb_bitrev(k)) : '0;
         vec[k].in_im        = '0 - vec[k].in_re;
         vec[k].out_ready    = 1'b1;
         vec[k].exp_in_ready = 1'b1;
         vec[k].exp_valid    = (k >= 16 && k < 32);
         vec[k].exp_re       = DATA_W'(k - 16);
         vec[k].exp_im       = '0 - DATA_W'(k - 16);
         vec[k].exp_idx      = LOG2N'(k - 16);
         vec[k].exp_last     = (k == 31);
      end
      for (int k = 0; k < 34; k++) begin
         bus.out_ready = vec[k].out_ready;
         set_in(vec[k].in_valid, vec[k].in_re, vec[k].in_im);
         step();
         check($sformatf("vec%0d_in_ready", k), bus.in_ready, vec[k].exp_in_ready);
         check($sformatf("vec%0d_valid", k), bus.out_valid, vec[k].exp_valid);
         if (vec[k].exp_valid) begin
            check($sformatf("vec%0d_re", k), bus.out_re, vec[k].exp_re);
            check($sformatf("vec%0d_im", k), bus.out_im, vec[k].exp_im);
            check($sformatf("vec%0d_index", k), bus.out_index, vec[k].exp_idx);
            check($sformatf("vec%0d_last", k), bus.out_last, vec[k].exp_last);
         end
      end
      drain("single");

      // Four back-to-back frames, both sides always ready.
      bus.out_ready = 1'b1;
      base = n_out; gaps = 0; ir_low = 0; seen = 1'b0;
      for (int k = 0; k < 64; k++) begin
         set_in(1'b1, DATA_W'($urandom), DATA_W'($urandom));
         if (!bus.in_ready) ir_low++;
         step();
         if (bus.out_valid) seen = 1'b1;
         else if (seen && (n_out - base) < 64) gaps++;
      end
      set_in(1'b0, '0, '0);
      g = 0;
      while ((n_out - base) < 64 && g < 100) begin
         step();
         if (!bus.out_valid && (n_out - base) < 64) gaps++;
         g++;
      end
      check("b2b_in_ready_low", ir_low, 0);
      check("b2b_gaps", gaps, 0);
      check("b2b_outputs", n_out - base, 64);
      drain("b2b");

      // Backpressure: both banks fill, first output holds at index 0.
      bus.out_ready = 1'b0;
      acc = 0;
      first_re = '0;
      r = DATA_W'($urandom);
      i = DATA_W'($urandom);
      for (int c = 0; c < 40; c++) begin
         set_in(1'b1, r, i);
         took = bus.in_ready;
         if (took && acc == 0) first_re = r;
         step();
         if (took) begin
            acc++;
            r = DATA_W'($urandom);
            i = DATA_W'($urandom);
         end
      end
      check("bp_accepts", acc, 32);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_valid", bus.out_valid, 1);
      check("bp_index", bus.out_index, 0);
      check("bp_data", bus.out_re, first_re);

      // Release: the bank frees on the index-15 load and accepts on the next edge.
      bus.out_ready = 1'b1;
      seen = 1'b0; extra = 0; prev_ir = 1'b0;
      for (int c = 0; c < 60 && !seen; c++) begin
         set_in(1'b1, r, i);
         took = bus.in_ready;
         prev_ir = bus.in_ready;
         step();
         if (took) begin
            extra++;
            r = DATA_W'($urandom);
            i = DATA_W'($urandom);
         end
         if (bus.out_valid && bus.out_last) begin
            seen = 1'b1;
            check("bp_release_prev_ready", prev_ir, 0);
            check("bp_release_now_ready", bus.in_ready, 1);
         end
      end
      check("bp_release_seen", seen, 1);
      check("bp_no_early_accept", extra, 0);
      set_in(1'b1, r, i);
      acc = n_acc;
      step();
      check("bp_33rd_accept", n_acc - acc, 1);
      send(N_POINTS - 1, 100);
      drain("bp");

      // out_ready toggling 1,0,1,0 during readout.
      send(N_POINTS, 0);
      base = n_out;
      for (int c = 0; c < 40; c++) begin
         bus.out_ready = (c % 2 == 0);
         set_in(1'b0, '0, '0);
         step();
      end
      drain("toggle");
      check("toggle_count", n_out - base, 16);

      // Reset mid-frame while an output is held.
      send(N_POINTS + 7, 0);
      rst = 1'b1;
      set_in(1'b0, '0, '0);
      step();
      check("midrst_valid", bus.out_valid, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_index", bus.out_index, 0);
      check("midrst_re", bus.out_re, 0);
      rst = 1'b0;
      base = n_out;
      send(N_POINTS, 100);
      drain("midrst");
      check("midrst_frame_count", n_out - base, 16);

      // Random traffic against the reference.
      for (int c = 0; c < 400; c++) begin
         bus.out_ready = ($urandom_range(9) < 6);
         set_in($urandom_range(9) < 7, DATA_W'($urandom), DATA_W'($urandom));
         step();
      end
      if (cur_cnt != 0) send(N_POINTS - cur_cnt, 60);
      drain("random");

`ifdef FFT_REORDER_SYNC_EN
      check("sync_clean", bus.sync_err, 0);
      send(5, 100);
      set_in(1'b1, DATA_W'($urandom), DATA_W'($urandom));
      bus.in_sof = 1'b1;
      step();
      check("sync_err_set", bus.sync_err, 1);
      check("sync_err_model", exp_sync, 1);
      send(N_POINTS - 1, 100);
      drain("sync_restart");
      set_in(1'b1, DATA_W'($urandom), DATA_W'($urandom));
      bus.in_sof = 1'b0;
      step();
      send(N_POINTS, 100);
      drain("sync_drop");
      check("sync_err_sticky", bus.sync_err, 1);
`endif

      check("final_queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
